stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
- Sequencer for a chain of cascaded decade (BCD) digit counters, i.e. a stopwatch core.
- Derives a count tick from clk through a prescaler and ripples carries across DIGITS decade stages.
- Runs a start/stop/lap/clear FSM and drives a BCD display bus, which can show either the live count or a frozen lap snapshot.
- Sits between debounced push-button pulses and the display driver.

Parameters:
- DIGITS, 4, number of cascaded decade digits (>=1).
- TICK_DIV, 10, clk cycles per count tick (>=1); prescaler width is clog2(TICK_DIV), minimum 1.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- start_stop  in  1  single-cycle command pulse: toggle run/pause.
- lap  in  1  single-cycle command pulse: freeze/release the display.
- clear  in  1  single-cycle command pulse: zero everything and return to IDLE.
- bcd_out  out  4*DIGITS  displayed count; digit i at bits [4i+3:4i], digit 0 is least significant.
- running  out  1  high in RUN and LAP.
- lap_active  out  1  high in LAP.
- tick  out  1  combinational; high on the cycle a count increment takes effect at the next edge.
- overflow  out  1  sticky; set when the count wraps from all-9s to all-0s.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, all digits=0, prescaler=0, snapshot=0, overflow=0. Consequently bcd_out=0, running=0, lap_active=0, tick=0. Reset overrides every command.
- States: IDLE, RUN, PAUSE, LAP. Commands are sampled at posedge; the new state is visible the following cycle.
- Command priority when pulses coincide: clear > start_stop > lap. Lower-priority pulses in the same cycle are ignored.
- clear, from any state: IDLE, digits=0, prescaler=0, overflow=0, snapshot=0.
- start_stop transitions:
  - IDLE->RUN
  - RUN->PAUSE
  - PAUSE->RUN
  - LAP->PAUSE; the display returns to the live count.
- lap transitions:
  - RUN->LAP; the snapshot captures the live digits on the same edge.
  - LAP->RUN.
  - Ignored in IDLE and PAUSE.
- Prescaler:
  - Increments every cycle in RUN or LAP.
  - tick = (RUN or LAP) && prescaler==TICK_DIV-1; on tick the prescaler goes to 0.
  - Holds its value in PAUSE, so a resumed run continues the partial period. It is zeroed only by rst or clear.
  - TICK_DIV=1 gives tick every counting cycle.
- Digit cascade:
  - Digit 0 is enabled by tick. Digit i is enabled by tick && all lower digits==9.
  - An enabled digit at 9 goes to 0; otherwise it increments by 1.
  - Digits never hold a value >9.
- Wrap: on a tick with all digits==9, every digit goes to 0 and overflow is set on that same edge. Counting continues after the wrap.
- bcd_out: shows the snapshot in LAP and the live digits in every other state. Internal counting continues during LAP.
- A command arriving on the same edge as tick: the increment still occurs on that edge, e.g. a start_stop to PAUSE does not lose the final tick. clear on the same edge as tick wins: the result is zero.
- Reset or clear mid-run leaves no residue: the next start counts from 0 with a full TICK_DIV period before the first tick.

Decomposition:
- Package stopwatch_pkg:
  - State encoding constants ST_IDLE, ST_RUN, ST_PAUSE, ST_LAP (2-bit).
  - BCD_MAX = 4'd9.
  - BCD_ZERO = 4'd0.
- Sub-module bcd_digit, one per digit via generate:
  - Inputs: clk, rst, clr, en.
  - Outputs: q[3:0]; carry = en && q==9 (combinational).
  - Synchronous clear; wraps 9->0.
  - The controller ANDs carries to form the chain.

Test Plan:
- 1. Reset: DIGITS=2, TICK_DIV=2; rst high 2 cycles -> bcd_out=0x00, running=0, overflow=0, tick never high while IDLE.
- 2. Count: start_stop pulse, then 20 cycles in RUN -> exactly 10 tick pulses, bcd_out=0x10, running=1.
- 3. Pause/resume: at bcd_out=0x07 with prescaler=1, start_stop; idle 50 cycles -> bcd_out stays 0x07. start_stop again -> tick on the first RUN cycle, bcd_out=0x08.
- 4. Lap: in RUN at 0x25, lap -> bcd_out frozen at 0x25 and lap_active=1 for 10 ticks. lap again -> bcd_out=0x35, lap_active=0.
- 5. Overflow: run 100 ticks from 0 -> bcd_out=0x00, overflow=1 and still set after 5 more ticks (bcd_out=0x05). clear -> overflow=0, IDLE, bcd_out=0x00.
- 6. Priority/mid-run reset: clear+start_stop+lap in the same cycle during RUN -> IDLE, 0x00. Separately, rst asserted in LAP at 0x42 -> all outputs zero next cycle.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch core: FSM state encoding, BCD digit
// limits and the single-digit decade increment.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_LAP   = 2'd3
   } state_e;

   localparam logic [3:0] BCD_MAX  = 4'd9;
   localparam logic [3:0] BCD_ZERO = 4'd0;

   function automatic logic [3:0] bcd_inc(input logic [3:0] v);
      logic [3:0] r;
      if (v >= BCD_MAX) begin
         r = BCD_ZERO;
      end else begin
         r = v + 4'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/stopwatch_bcd_digit.sv
// One decade stage of the stopwatch: counts 0..9 when enabled and flags a
// carry when it is about to wrap.
module bcd_digit
   import stopwatch_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       en,
   output logic [3:0] q,
   output logic       carry
);

   logic [3:0] q_q;
   logic [3:0] q_d;

   always_comb begin
      q_d = q_q;
      if (clr) begin
         q_d = BCD_ZERO;
      end else if (en) begin
         q_d = bcd_inc(q_q);
      end else begin
         q_d = q_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_q <= BCD_ZERO;
      end else begin
         q_q <= q_d;
      end
   end

   assign q     = q_q;
   assign carry = en && (q_q == BCD_MAX);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: prescaler, cascaded decade digits, start/stop/lap/clear
// FSM and the live/lap display mux.
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int DIGITS   = 4,
   parameter int TICK_DIV = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_stop,
   input  logic                  lap,
   input  logic                  clear,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic                  running,
   output logic                  lap_active,
   output logic                  tick,
   output logic                  overflow
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

   state_e              state_q, state_d;
   logic [PW-1:0]       pre_q, pre_d;
   logic [4*DIGITS-1:0] snap_q, snap_d;
   logic                ovf_q, ovf_d;

   logic [4*DIGITS-1:0] live;
   logic [DIGITS-1:0]   en;
   logic [DIGITS-1:0]   carry;
   logic                counting;
   logic                tick_int;
   logic                wrap;
   logic                lower_nine;
   logic                ss_cmd;
   logic                lap_cmd;

   for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      bcd_digit u_digit (
         .clk   (clk),
         .rst   (rst),
         .clr   (clear),
         .en    (en[i]),
         .q     (live[4*i +: 4]),
         .carry (carry[i])
      );
   end

   // A digit advances on a tick only when every lower digit is at 9.
   always_comb begin
      counting   = (state_q == ST_RUN) || (state_q == ST_LAP);
      tick_int   = counting && (pre_q == PRE_LAST);
      lower_nine = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         en[i]      = tick_int && lower_nine;
         lower_nine = lower_nine && (live[4*i +: 4] == BCD_MAX);
      end
   end

   assign wrap = &carry;

   always_comb begin
      ss_cmd  = start_stop && !clear;
      lap_cmd = lap && !clear && !start_stop;
      state_d = state_q;
      pre_d   = pre_q;
      snap_d  = snap_q;
      ovf_d   = ovf_q;
      if (clear) begin
         state_d = ST_IDLE;
         pre_d   = '0;
         snap_d  = '0;
         ovf_d   = 1'b0;
      end else begin
         if (tick_int) begin
            pre_d = '0;
         end else if (counting) begin
            pre_d = pre_q + PW'(1);
         end else begin
            pre_d = pre_q;
         end
         if (wrap) begin
            ovf_d = 1'b1;
         end else begin
            ovf_d = ovf_q;
         end
         case (state_q)
            ST_IDLE: begin
               if (ss_cmd) state_d = ST_RUN;
               else        state_d = ST_IDLE;
            end
            ST_RUN: begin
               if (ss_cmd) begin
                  state_d = ST_PAUSE;
               end else if (lap_cmd) begin
                  state_d = ST_LAP;
                  snap_d  = live;  // pre-increment value, even on a tick edge
               end else begin
                  state_d = ST_RUN;
               end
            end
            ST_PAUSE: begin
               if (ss_cmd) state_d = ST_RUN;
               else        state_d = ST_PAUSE;
            end
            ST_LAP: begin
               if (ss_cmd)       state_d = ST_PAUSE;
               else if (lap_cmd) state_d = ST_RUN;
               else              state_d = ST_LAP;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         pre_q   <= '0;
         snap_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pre_q   <= pre_d;
         snap_q  <= snap_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bcd_out    = (state_q == ST_LAP) ? snap_q : live;
   assign running    = counting;
   assign lap_active = (state_q == ST_LAP);
   assign tick       = tick_int;
   assign overflow   = ovf_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: directed vector table plus a
// randomized run, both checked against an integer-count reference model.
module tb_stopwatch_ctrl;

   localparam int DIGITS   = 2;
   localparam int TICK_DIV = 2;
   localparam int W        = 4 * DIGITS;
   localparam int MOD      = 100;
   localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_LAP = 3;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start_stop = 1'b0;
   logic         lap = 1'b0;
   logic         clear = 1'b0;
   logic [W-1:0] bcd_out;
   logic         running, lap_active, tick, overflow;

   int checks = 0;
   int errors = 0;
   int tick_seen = 0;

   int m_st = M_IDLE, m_pre = 0, m_cnt = 0, m_snap = 0;
   bit m_ovf = 1'b0;

   stopwatch_ctrl #(.DIGITS(DIGITS), .TICK_DIV(TICK_DIV)) dut (
      .clk        (clk),
      .rst        (rst),
      .start_stop (start_stop),
      .lap        (lap),
      .clear      (clear),
      .bcd_out    (bcd_out),
      .running    (running),
      .lap_active (lap_active),
      .tick       (tick),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit           rs, ss, lp, cl;
      int           n;
      logic [W-1:0] bcd;
      bit           run, lapa, ovf;
      int           ticks;
   } vec_t;

   vec_t vt[21];

   function automatic logic [W-1:0] to_bcd(input int v);
      logic [W-1:0] r = '0;
      int x = v;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: drive inputs, compare against the model, advance the model.
   task automatic step(input bit rs, input bit ss, input bit lp, input bit cl);
      bit counting, tk;
      int old_cnt;
      @(negedge clk);
      rst = rs; start_stop = ss; lap = lp; clear = cl;
      counting = (m_st == M_RUN) || (m_st == M_LAP);
      tk = counting && (m_pre == TICK_DIV - 1);
      chk("model_bcd", 32'(bcd_out), 32'(to_bcd(m_st == M_LAP ? m_snap : m_cnt)));
      chk("model_running", 32'(running), 32'(counting));
      chk("model_lap", 32'(lap_active), 32'(m_st == M_LAP));
      chk("model_tick", 32'(tick), 32'(tk));
      chk("model_ovf", 32'(overflow), 32'(m_ovf));
      if (tick === 1'b1) tick_seen++;
      if (rs || cl) begin
         m_st = M_IDLE; m_pre = 0; m_cnt = 0; m_snap = 0; m_ovf = 1'b0;
      end else begin
         old_cnt = m_cnt;
         if (counting) m_pre = tk ? 0 : m_pre + 1;
         if (tk) begin
            m_cnt = m_cnt + 1;
            if (m_cnt == MOD) begin
               m_cnt = 0;
               m_ovf = 1'b1;
            end
         end
         if (ss) begin
            case (m_st)
               M_IDLE:  m_st = M_RUN;
               M_RUN:   m_st = M_PAUSE;
               M_PAUSE: m_st = M_RUN;
               default: m_st = M_PAUSE;
            endcase
         end else if (lp) begin
            if (m_st == M_RUN) begin
               m_snap = old_cnt;
               m_st = M_LAP;
            end else if (m_st == M_LAP) begin
               m_st = M_RUN;
            end
         end
      end
      @(posedge clk);
   endtask

   initial begin
      //             rs ss lp cl  n    bcd     run lap ovf ticks
      vt[0]  = '{1, 0, 0, 0,   1, 8'h00, 0, 0, 0,   0};
      vt[1]  = '{0, 1, 0, 0,  20, 8'h10, 1, 0, 0,  10};
      vt[2]  = '{0, 0, 0, 1,   0, 8'h00, 0, 0, 0,  -1};
      vt[3]  = '{0, 1, 0, 0,  14, 8'h07, 1, 0, 0,   7};
      vt[4]  = '{0, 1, 0, 0,  50, 8'h07, 0, 0, 0,   0};
      vt[5]  = '{0, 1, 0, 0,   1, 8'h08, 1, 0, 0,   1};
      vt[6]  = '{0, 0, 0, 0,  33, 8'h25, 1, 0, 0,  -1};
      vt[7]  = '{0, 0, 1, 0,  19, 8'h25, 1, 1, 0,  10};
      vt[8]  = '{0, 0, 1, 0,   0, 8'h35, 1, 0, 0,  -1};
      vt[9]  = '{0, 0, 0, 1,   0, 8'h00, 0, 0, 0,  -1};
      vt[10] = '{0, 1, 0, 0, 200, 8'h00, 1, 0, 1, 100};
      vt[11] = '{0, 0, 0, 0,   9, 8'h05, 1, 0, 1,  -1};
      vt[12] = '{0, 0, 0, 1,   0, 8'h00, 0, 0, 0,  -1};
      vt[13] = '{0, 1, 0, 0,   6, 8'h03, 1, 0, 0,   3};
      vt[14] = '{0, 1, 1, 1,   0, 8'h00, 0, 0, 0,  -1};
      vt[15] = '{0, 1, 0, 0,  84, 8'h42, 1, 0, 0,  42};
      vt[16] = '{0, 0, 1, 0,   1, 8'h42, 1, 1, 0,   1};
      vt[17] = '{1, 0, 0, 0,   0, 8'h00, 0, 0, 0,  -1};
      vt[18] = '{0, 1, 0, 0,   1, 8'h00, 1, 0, 0,   0};
      vt[19] = '{0, 0, 0, 0,   0, 8'h01, 1, 0, 0,  -1};
      vt[20] = '{1, 1, 0, 0,   0, 8'h00, 0, 0, 0,  -1};

      // DUT state is unknown before the first reset edge, so no checks yet.
      repeat (2) @(posedge clk);

      for (int v = 0; v < 21; v++) begin
         step(vt[v].rs, vt[v].ss, vt[v].lp, vt[v].cl);
         tick_seen = 0;
         for (int k = 0; k < vt[v].n; k++) step(1'b0, 1'b0, 1'b0, 1'b0);
         #1;
         chk($sformatf("vec%0d_bcd", v), 32'(bcd_out), 32'(vt[v].bcd));
         chk($sformatf("vec%0d_running", v), 32'(running), 32'(vt[v].run));
         chk($sformatf("vec%0d_lap", v), 32'(lap_active), 32'(vt[v].lapa));
         chk($sformatf("vec%0d_ovf", v), 32'(overflow), 32'(vt[v].ovf));
         if (vt[v].ticks >= 0) chk($sformatf("vec%0d_ticks", v), 32'(tick_seen), 32'(vt[v].ticks));
      end

      for (int c = 0; c < 3000; c++) begin
         step($urandom_range(0, 199) == 0, $urandom_range(0, 11) == 0,
              $urandom_range(0, 9) == 0, $urandom_range(0, 59) == 0);
      end
      step(1'b0, 1'b0, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
